// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES trace sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package aes_seq_pkg;

    localparam int DEF_DATA_W = 128;
    localparam int DEF_CNT_W  = 16;
    localparam int DEF_GAP_W  = 8;

    // Feedback taps for x^128 + x^7 + x^2 + x + 1 in left-shifting Galois form.
    localparam logic [127:0] LFSR_TAPS = 128'h87;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MODE_FIXED = 2'b00,
        MODE_INCR  = 2'b01,
        MODE_LFSR  = 2'b10,
        MODE_TVLA  = 2'b11
    } mode_t;

endpackage

// File: rtl/aes_seq_lfsr.sv
// Galois LFSR supplying pseudo-random plaintexts; an all-zero load is replaced by SEED.
// Latency: load/step take effect on the next clock edge; o_state is the register output.
// Backpressure: none; i_load has priority over i_step.
module aes_seq_lfsr
    import aes_seq_pkg::*;
#(
    parameter int             W    = DEF_DATA_W,
    parameter logic [W-1:0]   SEED = W'(1)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_step,
    output logic [W-1:0] o_state
);

    logic [W-1:0] r_state;
    logic [W-1:0] w_next;

    // One Galois step: shift left, fold the outgoing MSB back through the taps.
    always_comb begin
        w_next = {r_state[W-2:0], 1'b0};
        if (r_state[W-1]) begin
            w_next = w_next ^ LFSR_TAPS[W-1:0];
        end
    end

    // State register; zero would lock the LFSR, so it is swapped for SEED.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= SEED;
        end else if (i_load) begin
            r_state <= (i_load_val == '0) ? SEED : i_load_val;
        end else if (i_step) begin
            r_state <= w_next;
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/aes_trace_sequencer.sv
// Drives an AES core through N back-to-back encryptions under one key and captures each ciphertext.
// Latency: start at cycle t gives first AES_en at t+2; per trace = core latency + 1 + max(gap,1) + 1.
// Backpressure: none; start is only accepted in IDLE, a silent core aborts the run after TIMEOUT cycles.
module aes_trace_sequencer
    import aes_seq_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                CNT_W     = DEF_CNT_W,
    parameter int                GAP_W     = DEF_GAP_W,
    parameter int                TIMEOUT   = 64,
    parameter int                BYTE_SEL  = 12,
    parameter logic [DATA_W-1:0] LFSR_SEED = DATA_W'(1)
) (
    input  logic              AES_clk,
    input  logic              AES_rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  num_traces,
    input  logic [GAP_W-1:0]  gap_cycles,
    input  logic [DATA_W-1:0] base_pt,
    input  logic [DATA_W-1:0] key,
    input  logic [DATA_W-1:0] AES_data_out,
    input  logic              AES_data_out_valid,
    output logic              AES_en,
    output logic [DATA_W-1:0] AES_data_in,
    output logic [DATA_W-1:0] AES_key_in,
    output logic              busy,
    output logic              done,
    output logic              trigger,
    output logic [DATA_W-1:0] ct_out,
    output logic              ct_valid,
    output logic [CNT_W-1:0]  trace_idx,
    output logic              timeout_err
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    state_t            r_state;
    state_t            w_state_nxt;
    mode_t             r_mode;
    logic [CNT_W-1:0]  r_num;
    logic [CNT_W-1:0]  r_trace_idx;
    logic [GAP_W-1:0]  r_gap;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [TMR_W-1:0]  r_tmr;
    logic [DATA_W-1:0] r_base;
    logic [DATA_W-1:0] r_key;
    logic [DATA_W-1:0] r_data_in;
    logic [DATA_W-1:0] r_ct;
    logic              r_en;
    logic              r_trig;
    logic              r_ct_vld;
    logic              r_err;

    logic              w_accept;
    logic              w_load;
    logic              w_capture;
    logic              w_timeout;
    logic              w_gap_end;
    logic              w_last;
    logic              w_use_lfsr;
    logic [GAP_W-1:0]  w_gap_eff;
    logic [7:0]        w_incr_byte;
    logic [DATA_W-1:0] w_pt;
    logic [DATA_W-1:0] w_lfsr;

    assign w_load     = (r_state == ST_LOAD);
    assign w_last     = ((r_trace_idx + CNT_W'(1)) == r_num);
    assign w_gap_eff  = (r_gap == '0) ? GAP_W'(1) : r_gap;
    // The LFSR only advances when its value was actually consumed for this trace.
    assign w_use_lfsr = w_load && ((r_mode == MODE_LFSR) ||
                                   ((r_mode == MODE_TVLA) && r_trace_idx[0]));

    aes_seq_lfsr #(
        .W    (DATA_W),
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .i_clk      (AES_clk),
        .i_rst_n    (AES_rst_n),
        .i_load     (w_accept),
        .i_load_val (base_pt),
        .i_step     (w_use_lfsr),
        .o_state    (w_lfsr)
    );

    // Next-state and control strobes; valid is checked before timeout so a late result still counts.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_gap_end   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (num_traces == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (AES_data_out_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_GAP;
                end else if (r_tmr == TMR_W'(TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == (w_gap_eff - GAP_W'(1))) begin
                    w_gap_end   = 1'b1;
                    w_state_nxt = w_last ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Plaintext for the trace about to be loaded, chosen by the latched mode.
    always_comb begin
        w_pt        = r_base;
        w_incr_byte = r_base[8*BYTE_SEL +: 8] + r_trace_idx[7:0];
        case (r_mode)
            MODE_INCR: w_pt[8*BYTE_SEL +: 8] = w_incr_byte;
            MODE_LFSR: w_pt = w_lfsr;
            MODE_TVLA: begin
                if (r_trace_idx[0]) begin
                    w_pt = w_lfsr;
                end
            end
            default: w_pt = r_base;
        endcase
    end

    // FSM state register.
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequence configuration, captured once per accepted start.
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            r_mode <= MODE_FIXED;
            r_num  <= '0;
            r_gap  <= '0;
            r_base <= '0;
            r_key  <= '0;
        end else if (w_accept) begin
            r_mode <= mode_t'(mode);
            r_num  <= num_traces;
            r_gap  <= gap_cycles;
            r_base <= base_pt;
            r_key  <= key;
        end
    end

    // Core drive, capture, per-trace counters and the sticky error flag.
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            r_en        <= 1'b0;
            r_trig      <= 1'b0;
            r_ct_vld    <= 1'b0;
            r_err       <= 1'b0;
            r_data_in   <= '0;
            r_ct        <= '0;
            r_trace_idx <= '0;
            r_tmr       <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_trig   <= w_load;
            r_ct_vld <= w_capture;

            if (w_load) begin
                r_en <= 1'b1;
            end else if (w_capture || w_timeout) begin
                r_en <= 1'b0;
            end

            if (w_load) begin
                r_data_in <= w_pt;
            end

            if (w_capture) begin
                r_ct <= AES_data_out;
            end

            if (w_accept) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end

            // The index stays on the last trace once the sequence completes.
            if (w_accept) begin
                r_trace_idx <= '0;
            end else if (w_gap_end && !w_last) begin
                r_trace_idx <= r_trace_idx + CNT_W'(1);
            end

            if (w_load) begin
                r_tmr <= '0;
            end else if (r_state == ST_RUN) begin
                r_tmr <= r_tmr + TMR_W'(1);
            end

            if (w_capture) begin
                r_gap_cnt <= '0;
            end else if (r_state == ST_GAP) begin
                r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end
        end
    end

    assign AES_en      = r_en;
    assign AES_data_in = r_data_in;
    assign AES_key_in  = r_key;
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign trigger     = r_trig;
    assign ct_out      = r_ct;
    assign ct_valid    = r_ct_vld;
    assign trace_idx   = r_trace_idx;
    assign timeout_err = r_err;

endmodule

// File: tb/tb_aes_trace_sequencer.sv
// Directed bench for aes_trace_sequencer with a behavioural AES core stand-in.
// Latency: the stand-in returns a result mock_lat+1 enabled cycles after AES_en rises.
// Backpressure: none; the stand-in can be muted to provoke the timeout path.
`timescale 1ns/1ps
module tb_aes_trace_sequencer;
    import aes_seq_pkg::*;

    localparam int CW = 16;
    localparam int GW = 8;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] INCR_KEY = 128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic [1:0]    mode     = 2'b00;
    logic [CW-1:0] num      = '0;
    logic [GW-1:0] gap      = '0;
    logic [127:0]  base     = '0;
    logic [127:0]  key      = '0;
    logic [127:0]  dout     = '0;
    logic          dout_vld = 1'b0;

    logic          aes_en;
    logic [127:0]  aes_data_in;
    logic [127:0]  aes_key_in;
    logic          busy;
    logic          done;
    logic          trigger;
    logic [127:0]  ct_out;
    logic          ct_valid;
    logic [CW-1:0] trace_idx;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;

    logic mock_on  = 1'b1;
    int   mock_lat = 10;
    int   mock_cnt = 0;

    int           n_en    = 0;
    int           n_trig  = 0;
    int           n_ctv   = 0;
    int           low_run = 0;
    logic [127:0] pt_q[$];
    int           low_q[$];

    aes_trace_sequencer dut (
        .AES_clk            (clk),
        .AES_rst_n          (rst_n),
        .start              (start),
        .mode               (mode),
        .num_traces         (num),
        .gap_cycles         (gap),
        .base_pt            (base),
        .key                (key),
        .AES_data_out       (dout),
        .AES_data_out_valid (dout_vld),
        .AES_en             (aes_en),
        .AES_data_in        (aes_data_in),
        .AES_key_in         (aes_key_in),
        .busy               (busy),
        .done               (done),
        .trigger            (trigger),
        .ct_out             (ct_out),
        .ct_valid           (ct_valid),
        .trace_idx          (trace_idx),
        .timeout_err        (timeout_err)
    );

    always #5 clk = ~clk;

    // Stand-in core result: the real FIPS-197 answer for its vector, pt^key otherwise.
    function automatic logic [127:0] mock_ct(input logic [127:0] p, input logic [127:0] k);
        if (p == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        return p ^ k;
    endfunction

    // Stand-in core: pulses valid once after mock_lat enabled cycles.
    always @(posedge clk) begin
        if (aes_en) begin
            if (mock_on && mock_cnt == mock_lat - 1) begin
                dout_vld <= 1'b1;
                dout     <= mock_ct(aes_data_in, aes_key_in);
            end else begin
                dout_vld <= 1'b0;
            end
            mock_cnt <= mock_cnt + 1;
        end else begin
            dout_vld <= 1'b0;
            mock_cnt <= 0;
        end
    end

    // Observer: plaintext at each trigger, idle run before it, strobe and enable counts.
    always @(negedge clk) begin
        if (trigger) begin
            pt_q.push_back(aes_data_in);
            low_q.push_back(low_run);
            n_trig++;
        end
        if (ct_valid) n_ctv++;
        if (aes_en) begin
            n_en++;
            low_run = 0;
        end else begin
            low_run++;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%032h expected=%032h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        assert (done === 1'b1) else begin
            errors++;
            $error("FAIL %s observed done=%0b expected=1 within %0d cycles", tag, done, budget);
        end
    endtask

    task automatic do_start(input logic [1:0] m, input int n, input int g,
                            input logic [127:0] p, input logic [127:0] k);
        @(negedge clk);
        mode  = m;
        num   = CW'(n);
        gap   = GW'(g);
        base  = p;
        key   = k;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, c0, e0, q0;

        // Reset values
        repeat (3) @(negedge clk);
        chk_i("rst_ctl", int'({aes_en, busy, done, trigger, ct_valid, timeout_err}), 0);
        chk("rst_data_in", aes_data_in, '0);
        chk("rst_ct_out", ct_out, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_i("rst_idx", int'(trace_idx), 0);
        chk("rst_key_in", aes_key_in, '0);

        // FIPS-197 vector, FIXED mode, one trace; first AES_en two cycles after start
        mock_on = 1'b1; mock_lat = 10;
        t0 = n_trig; c0 = n_ctv;
        do_start(MODE_FIXED, 1, 2, FIPS_PT, FIPS_KEY);
        chk_b("load_en_low", aes_en, 1'b0);
        chk_b("load_busy", busy, 1'b1);
        @(negedge clk);
        chk_b("first_en", aes_en, 1'b1);
        chk_b("first_trig", trigger, 1'b1);
        chk("fips_pt", aes_data_in, FIPS_PT);
        chk("fips_key", aes_key_in, FIPS_KEY);
        wait_done("fips_done", 100);
        chk("fips_ct", ct_out, FIPS_CT);
        chk_i("fips_ctv", n_ctv - c0, 1);
        chk_i("fips_trig", n_trig - t0, 1);
        @(negedge clk);
        chk_b("fips_idle", busy, 1'b0);

        // INCR: byte 12 steps 7f, 80, 81
        q0 = pt_q.size(); t0 = n_trig; c0 = n_ctv;
        do_start(MODE_INCR, 3, 4, 128'h0000007f_00000000_00000000_00000000, INCR_KEY);
        wait_done("incr_done", 200);
        chk_i("incr_trig", n_trig - t0, 3);
        chk_i("incr_ctv", n_ctv - c0, 3);
        chk("incr_pt0", pt_q[q0],   128'h0000007f_00000000_00000000_00000000);
        chk("incr_pt1", pt_q[q0+1], 128'h00000080_00000000_00000000_00000000);
        chk("incr_pt2", pt_q[q0+2], 128'h00000081_00000000_00000000_00000000);
        chk_b("incr_gap1", low_q[q0+1] >= 4, 1'b1);
        chk_b("incr_gap2", low_q[q0+2] >= 4, 1'b1);
        chk_i("incr_idx", int'(trace_idx), 2);
        chk("incr_ct", ct_out, 128'h00000081_00000000_00000000_00000000 ^ INCR_KEY);

        // INCR wrap ff -> 00 with no carry; gap 0 still leaves at least one idle GAP cycle
        q0 = pt_q.size();
        do_start(MODE_INCR, 2, 0, 128'h012345ff_89abcdef_01234567_89abcdef, INCR_KEY);
        wait_done("wrap_done", 200);
        chk("wrap_pt0", pt_q[q0],   128'h012345ff_89abcdef_01234567_89abcdef);
        chk("wrap_pt1", pt_q[q0+1], 128'h01234500_89abcdef_01234567_89abcdef);
        chk_b("wrap_mingap", low_q[q0+1] >= 2, 1'b1);

        // TVLA with zero base: even traces 0, odd traces walk the LFSR from seed 1
        q0 = pt_q.size();
        do_start(MODE_TVLA, 4, 1, '0, INCR_KEY);
        wait_done("tvla_done", 300);
        chk("tvla_pt0", pt_q[q0],   128'h0);
        chk("tvla_pt1", pt_q[q0+1], 128'h1);
        chk("tvla_pt2", pt_q[q0+2], 128'h0);
        chk("tvla_pt3", pt_q[q0+3], 128'h2);

        // LFSR mode: MSB set exercises the feedback taps
        q0 = pt_q.size();
        do_start(MODE_LFSR, 3, 1, 128'h80000000_00000000_00000000_00000001, INCR_KEY);
        wait_done("lfsr_done", 300);
        chk("lfsr_pt0", pt_q[q0],   128'h80000000_00000000_00000000_00000001);
        chk("lfsr_pt1", pt_q[q0+1], 128'h85);
        chk("lfsr_pt2", pt_q[q0+2], 128'h10a);

        // Timeout: silent core holds AES_en for exactly 64 cycles
        mock_on = 1'b0;
        e0 = n_en; c0 = n_ctv;
        do_start(MODE_FIXED, 1, 1, FIPS_PT, FIPS_KEY);
        wait_done("to_done", 200);
        chk_i("to_en_cycles", n_en - e0, 64);
        chk_b("to_err", timeout_err, 1'b1);
        chk_i("to_ctv", n_ctv - c0, 0);

        // Valid landing on the last allowed RUN cycle wins; new start clears the error
        mock_on = 1'b1; mock_lat = 63;
        c0 = n_ctv;
        do_start(MODE_FIXED, 1, 1, FIPS_PT, FIPS_KEY);
        chk_b("err_clr", timeout_err, 1'b0);
        wait_done("edge_done", 200);
        chk_b("edge_no_err", timeout_err, 1'b0);
        chk_i("edge_ctv", n_ctv - c0, 1);
        chk("edge_ct", ct_out, FIPS_CT);

        // num_traces = 0: done the cycle after start, no enable
        mock_lat = 5;
        e0 = n_en;
        do_start(MODE_FIXED, 0, 1, FIPS_PT, FIPS_KEY);
        chk_b("zero_done", done, 1'b1);
        repeat (3) @(negedge clk);
        chk_b("zero_idle", busy, 1'b0);
        chk_i("zero_en", n_en - e0, 0);

        // start while busy is ignored
        t0 = n_trig;
        do_start(MODE_FIXED, 2, 2, FIPS_PT, FIPS_KEY);
        repeat (3) @(negedge clk);
        mode = MODE_INCR; num = CW'(7); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_done", 200);
        chk_i("busy_trig", n_trig - t0, 2);
        chk_i("busy_idx", int'(trace_idx), 1);

        // Asynchronous reset mid-RUN
        mock_on = 1'b0;
        do_start(MODE_FIXED, 1, 1, FIPS_PT, FIPS_KEY);
        repeat (5) @(negedge clk);
        chk_b("mid_en", aes_en, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_b("arst_en", aes_en, 1'b0);
        chk_b("arst_busy", busy, 1'b0);
        chk_b("arst_done", done, 1'b0);
        chk("arst_key", aes_key_in, '0);
        @(negedge clk);
        rst_n = 1'b1;
        mock_on = 1'b1;
        repeat (2) @(negedge clk);
        chk_b("post_rst_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_trace_sequencer.md
Name: aes_trace_sequencer

Overview:
- Synthesizable stimulus/capture engine for side-channel trace collection.
- Sits between the host/config logic and AES_top; drives AES_en, AES_data_in and AES_key_in, and collects AES_data_out on AES_data_out_valid.
- Runs N encryptions back-to-back under a fixed key, with programmable plaintext mode and inter-trace gap.
- Emits a scope trigger pulse and a per-trace ciphertext strobe.

Parameters:
- DATA_W, 128, plaintext/key/ciphertext width
- CNT_W, 16, width of trace counter and num_traces
- GAP_W, 8, width of gap_cycles
- TIMEOUT, 64, maximum RUN cycles waiting for AES_data_out_valid
- BYTE_SEL, 12, byte varied in INCR mode: bits [8*BYTE_SEL+7 : 8*BYTE_SEL]
- LFSR_SEED, 128'h1, LFSR seed used when base_pt is all-zero

Ports:
- AES_clk  in  1  clock
- AES_rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a sequence
- mode  in  2  00 FIXED, 01 INCR, 10 LFSR, 11 TVLA (fixed/random interleave)
- num_traces  in  CNT_W  traces to run
- gap_cycles  in  GAP_W  idle cycles between traces (min 1 enforced)
- base_pt  in  DATA_W  base plaintext / LFSR seed
- key  in  DATA_W  encryption key
- AES_data_out  in  DATA_W  core ciphertext
- AES_data_out_valid  in  1  core result valid
- AES_en  out  1  core enable
- AES_data_in  out  DATA_W  core plaintext
- AES_key_in  out  DATA_W  core key
- busy  out  1  sequence in progress
- done  out  1  one-cycle end-of-sequence pulse
- trigger  out  1  one-cycle pulse on first AES_en cycle of each trace
- ct_out  out  DATA_W  last captured ciphertext
- ct_valid  out  1  one-cycle capture strobe
- trace_idx  out  CNT_W  index of current/last trace
- timeout_err  out  1  sticky error; cleared on next accepted start

Behaviour:
- Clock and reset: single clock AES_clk. Reset is asynchronous, active-low (AES_rst_n).
- Reset values: all outputs 0, state IDLE, LFSR = LFSR_SEED.
- States: IDLE, LOAD, RUN, GAP, DONE.
- IDLE:
  - start=1 latches mode, num_traces, gap_cycles, base_pt and key; clears timeout_err and trace_idx; goes to LOAD.
  - If num_traces=0, goes to DONE instead.
  - LFSR loads base_pt, or LFSR_SEED if base_pt=0.
  - start is ignored in every non-IDLE state.
- LOAD (1 cycle): registers AES_data_in for trace trace_idx.
  - FIXED: base_pt.
  - INCR: base_pt with selected byte = base byte + trace_idx[7:0], mod 256; other bytes unchanged.
  - LFSR: current LFSR value.
  - TVLA: even trace_idx uses base_pt; odd uses LFSR value.
  - LFSR advances one step (Galois, x^128+x^7+x^2+x+1) after each use in LFSR/TVLA mode.
  - AES_key_in = latched key, stable for the whole sequence.
- RUN:
  - AES_en=1; trigger=1 on the first RUN cycle only.
  - AES_data_in/AES_key_in are held constant.
  - On AES_data_out_valid: ct_out<=AES_data_out and ct_valid pulses next cycle. AES_en deasserts next cycle. Go to GAP.
  - TIMEOUT cycles without valid: timeout_err<=1, AES_en<=0, go to DONE (abort).
- GAP: AES_en=0 for max(gap_cycles,1) cycles.
  - Then trace_idx+1. If trace_idx+1 == num_traces go to DONE, else LOAD.
  - trace_idx wraps never, since num_traces ≤ 2^CNT_W−1.
- DONE (1 cycle): done=1, then IDLE. busy=1 in every state except IDLE.
- Latency: start at cycle t gives first AES_en at t+2. Per-trace period = core latency + 1 + max(gap,1) + 1 (LOAD).
- AES_data_out_valid outside RUN is ignored.
- Valid arriving in the same cycle the TIMEOUT count expires: valid wins and there is no error.
- Reset mid-sequence: immediate return to IDLE and all outputs 0; no done pulse.

Decomposition:
- Package aes_seq_pkg holds:
  - state enum
  - mode encodings (MODE_FIXED/INCR/LFSR/TVLA)
  - LFSR tap constant
  - default widths
- One sub-module, aes_seq_lfsr: 128-bit Galois LFSR with load/step/zero-seed substitution.

Test Plan:
- FIPS-197 check: FIXED mode, num_traces=1, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff against real AES_top. Expect ct_out=69c4e0d86a7b0430d8cdb78070b4c55a, one ct_valid, one trigger, then done.
- INCR mode: key aa2bdb40bff6a5e8caa9ba3ebc1e2acc, base 0000007f_00000000_00000000_00000000, num_traces=3, gap=4. Expect AES_data_in bits[103:96] = 7f, 80, 81, all other bits 0. Expect 3 triggers, AES_en low ≥4 cycles between traces, and trace_idx ending at 2.
- INCR wrap: base byte ff, num_traces=2. Expect byte values ff then 00, with no carry into neighbouring bytes.
- TVLA mode, num_traces=4, base_pt=0. Expect traces 0 and 2 = 0; traces 1 and 3 = LFSR outputs from LFSR_SEED (steps 0 and 1, matched against the reference model).
- Timeout: mock core never asserts valid, TIMEOUT=64. Expect AES_en high exactly 64 cycles, then timeout_err=1, done pulse, and no ct_valid. A new start clears timeout_err.
- Corner cases:
  - num_traces=0: done 1 cycle after start, AES_en never asserted.
  - start while busy: ignored.
  - AES_rst_n low mid-RUN: AES_en=0 asynchronously and busy=0.
